// File: rtl/freq_counter_mc.sv
// freq_counter_mc: multi-channel gate-time frequency counter.
// Each asynchronous meas_in bit is synchronised into clk_ref. Its rising edges
// are then counted over a programmable gate window of clk_ref cycles.
// Ports:
//   clk_ref    - reference clock, the only clock in the block
//   rst        - synchronous active-high reset
//   meas_in    - asynchronous measured signals, bit i = channel i
//   gate_len   - window length in clk_ref cycles, latched at each window start
//                (0 is treated as 1)
//   start      - single-shot trigger, sampled while idle
//   continuous - run windows back-to-back with no gap
//   freq       - per-channel results, channel i at [i*CNTR_SIZE +: CNTR_SIZE]
//   ovf        - per-channel saturation flags for the last completed window
//   valid      - one-cycle strobe, freq/ovf updated
//   busy       - high while a window is open
module freq_counter_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNTR_SIZE   = 16,
  parameter int unsigned GATE_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk_ref,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           meas_in,
  input  logic [GATE_W-1:0]           gate_len,
  input  logic                        start,
  input  logic                        continuous,
  output logic [NUM_CH*CNTR_SIZE-1:0] freq,
  output logic [NUM_CH-1:0]           ovf,
  output logic                        valid,
  output logic                        busy
);

  localparam logic [CNTR_SIZE-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t                 state_q;
  logic [NUM_CH-1:0]      sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]      prev_q;
  logic [NUM_CH-1:0]      edge_c;
  logic [CNTR_SIZE-1:0]   cnt_q   [NUM_CH];
  logic [CNTR_SIZE-1:0]   cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]      sticky_q;
  logic [NUM_CH-1:0]      sat_hit;
  logic [GATE_W-1:0]      gate_cnt_q;
  logic [GATE_W-1:0]      len_q;
  logic [GATE_W-1:0]      len_eff_c;
  logic                   last_c;

  // Synchroniser chain plus edge-detect history; runs in every state.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= meas_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign len_eff_c = (gate_len == '0) ? GATE_W'(1) : gate_len;
  assign last_c    = (gate_cnt_q == len_q - GATE_W'(1));

  // Saturating next count per channel; sat_hit marks an edge lost at the ceiling.
  always_comb begin
    sat_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sat_hit[i] = edge_c[i] & (cnt_q[i] == CNT_MAX);
      cnt_nxt[i] = sat_hit[i] ? cnt_q[i] : cnt_q[i] + CNTR_SIZE'(edge_c[i]);
    end
  end

  // Window control, channel accumulators and registered result outputs.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      freq       <= '0;
      ovf        <= '0;
      gate_cnt_q <= '0;
      len_q      <= '0;
      sticky_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || continuous) begin
            state_q    <= GATE;
            busy       <= 1'b1;
            len_q      <= len_eff_c;
            gate_cnt_q <= '0;
            sticky_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
          end
        end
        GATE: begin
          if (last_c) begin
            // The edge seen on the last cycle is folded into this result.
            for (int i = 0; i < NUM_CH; i++) begin
              freq[i*CNTR_SIZE +: CNTR_SIZE] <= cnt_nxt[i];
              cnt_q[i] <= '0;
            end
            ovf        <= sticky_q | sat_hit;
            sticky_q   <= '0;
            valid      <= 1'b1;
            gate_cnt_q <= '0;
            if (continuous) begin
              len_q <= len_eff_c;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_nxt[i];
            sticky_q   <= sticky_q | sat_hit;
            gate_cnt_q <= gate_cnt_q + GATE_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_counter_mc.sv
// Self-checking bench for freq_counter_mc (2 channels, 10-bit counters).
// Expected window results go into a scoreboard queue when a window is started
// and are popped and compared whenever the DUT strobes valid.
module tb_freq_counter_mc;
  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned CNTR_SIZE   = 10;
  localparam int unsigned GATE_W      = 16;
  localparam int unsigned SYNC_STAGES = 2;

  logic                        clk_ref = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_CH-1:0]           meas_in;
  logic [GATE_W-1:0]           gate_len = '0;
  logic                        start = 1'b0;
  logic                        continuous = 1'b0;
  logic [NUM_CH*CNTR_SIZE-1:0] freq;
  logic [NUM_CH-1:0]           ovf;
  logic                        valid;
  logic                        busy;

  freq_counter_mc #(
    .NUM_CH(NUM_CH), .CNTR_SIZE(CNTR_SIZE), .GATE_W(GATE_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_ref(clk_ref), .rst(rst), .meas_in(meas_in), .gate_len(gate_len),
    .start(start), .continuous(continuous), .freq(freq), .ovf(ovf),
    .valid(valid), .busy(busy)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    int         f0;
    int         f1;
    logic [1:0] ov;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int valid_cnt = 0;
  int valid_neg = 0;
  int sum_f1 = 0;

  // Square-wave generators (period 0 = held low) and manual override levels.
  int         per [NUM_CH] = '{0, 0};
  int         ph  [NUM_CH] = '{0, 0};
  logic [1:0] gen_meas = '0;
  logic [1:0] gen_en   = '0;
  logic [1:0] man_meas = '0;

  assign meas_in = (gen_en & gen_meas) | (~gen_en & man_meas);

  always @(negedge clk_ref) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (per[i] == 0) begin
        gen_meas[i] = 1'b0;
      end else begin
        ph[i] = (ph[i] + 1) % per[i];
        gen_meas[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  // Scoreboard monitor: every valid pops one expected window result.
  always @(negedge clk_ref) begin
    exp_t e;
    neg_cnt++;
    if (valid === 1'b1) begin
      valid_cnt++;
      valid_neg = neg_cnt;
      sum_f1 += int'(freq[19:10]);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid cycle=%0d freq0=%0d freq1=%0d", neg_cnt, freq[9:0], freq[19:10]);
      end else begin
        e = sb.pop_front();
        if (freq[9:0] !== 10'(e.f0) || freq[19:10] !== 10'(e.f1) || ovf !== e.ov) begin
          errors++;
          $display("FAIL sb_result cycle=%0d got f0=%0d f1=%0d ovf=%b expected f0=%0d f1=%0d ovf=%b",
                   neg_cnt, freq[9:0], freq[19:10], ovf, e.f0, e.f1, e.ov);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_ref);
      #1;
    end
  endtask

  // One-cycle start pulse; t0 is the cycle index it was driven in.
  task automatic start_pulse(output int t0);
    start = 1'b1;
    t0 = neg_cnt;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valids(input int n, input int budget, output bit timed_out);
    for (int k = 0; k < budget && valid_cnt < n; k++) tick(1);
    timed_out = (valid_cnt < n);
  endtask

  task automatic gens_off();
    gen_en = '0;
    man_meas = '0;
    per[0] = 0;
    per[1] = 0;
  endtask

  task automatic test_reset();
    int v0;
    per[0] = 4;
    per[1] = 4;
    gen_en = 2'b11;
    rst = 1'b1;
    tick(3);
    checks++; if (freq !== '0)   begin errors++; $display("FAIL reset_freq got=%h exp=0", freq); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    v0 = valid_cnt;
    tick(50);
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL reset_idle_valids got=%0d exp=%0d", valid_cnt, v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    gens_off();
    tick(5);
  endtask

  task automatic test_single();
    int v0, t0;
    bit to;
    per[0] = 10;
    gen_en = 2'b01;
    gate_len = 16'd1000;
    tick(20);
    sb.push_back('{100, 0, 2'b00});
    v0 = valid_cnt;
    start_pulse(t0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_valids(v0 + 1, 1100, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout valids=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (valid_neg != t0 + 1001) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", valid_neg - t0, 1001); end
    tick(30);
    checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL single_count got=%0d exp=%0d", valid_cnt - v0, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    gens_off();
  endtask

  task automatic test_saturation();
    int v0, t0;
    bit to;
    per[0] = 4;
    gen_en = 2'b01;
    tick(20);
    gate_len = 16'd8000;
    sb.push_back('{1023, 0, 2'b01});
    v0 = valid_cnt;
    start_pulse(t0);
    wait_valids(v0 + 1, 8100, to);
    checks++; if (to) begin errors++; $display("FAIL sat_timeout valids=%0d exp=%0d", valid_cnt, v0 + 1); end
    tick(5);
    gate_len = 16'd400;
    sb.push_back('{100, 0, 2'b00});
    start_pulse(t0);
    wait_valids(v0 + 2, 500, to);
    checks++; if (to) begin errors++; $display("FAIL sat_rerun_timeout valids=%0d exp=%0d", valid_cnt, v0 + 2); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL sat_ovf_clear got=%b exp=00", ovf); end
    gens_off();
    tick(10);
  endtask

  task automatic test_back_to_back();
    int v0, s0, n9;
    bit to;
    per[1] = 5;
    gen_en = 2'b10;
    tick(20);
    gate_len = 16'd100;
    for (int k = 0; k < 11; k++) sb.push_back('{0, 20, 2'b00});
    v0 = valid_cnt;
    s0 = sum_f1;
    continuous = 1'b1;
    wait_valids(v0 + 9, 1000, to);
    n9 = valid_neg;
    wait_valids(v0 + 10, 200, to);
    checks++; if (to) begin errors++; $display("FAIL cont_timeout valids=%0d exp=%0d", valid_cnt - v0, 10); end
    checks++; if (valid_neg - n9 != 100) begin errors++; $display("FAIL cont_period got=%0d exp=100", valid_neg - n9); end
    checks++; if (sum_f1 - s0 != 200) begin errors++; $display("FAIL cont_sum got=%0d exp=200", sum_f1 - s0); end
    tick(50);
    continuous = 1'b0;
    wait_valids(v0 + 11, 200, to);
    tick(20);
    checks++; if (valid_cnt != v0 + 11) begin errors++; $display("FAIL cont_stop_count got=%0d exp=11", valid_cnt - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy got=%b exp=0", busy); end
    gens_off();
    tick(10);
  endtask

  // Single ch0 edge on the last cycle of window 1, then on the first of window 3.
  task automatic test_window_boundary();
    int v0;
    bit to;
    gate_len = 16'd10;
    sb.push_back('{1, 0, 2'b00});
    sb.push_back('{0, 0, 2'b00});
    sb.push_back('{1, 0, 2'b00});
    v0 = valid_cnt;
    continuous = 1'b1;
    tick(8);
    man_meas[0] = 1'b1;
    tick(4);
    man_meas[0] = 1'b0;
    tick(7);
    man_meas[0] = 1'b1;
    tick(5);
    continuous = 1'b0;
    man_meas[0] = 1'b0;
    wait_valids(v0 + 3, 100, to);
    tick(10);
    checks++; if (valid_cnt != v0 + 3) begin errors++; $display("FAIL boundary_count got=%0d exp=3", valid_cnt - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL boundary_busy got=%b exp=0", busy); end
  endtask

  task automatic test_corners();
    int v0, v1, t0, t1;
    bit to;
    // Zero gate length acts as one cycle.
    gate_len = '0;
    sb.push_back('{0, 0, 2'b00});
    v0 = valid_cnt;
    start_pulse(t0);
    wait_valids(v0 + 1, 20, to);
    checks++; if (to || valid_neg != t0 + 2) begin errors++; $display("FAIL gate0_latency got=%0d exp=2", valid_neg - t0); end
    tick(5);
    // A start pulse while busy is ignored.
    gate_len = 16'd50;
    sb.push_back('{0, 0, 2'b00});
    v0 = valid_cnt;
    start_pulse(t0);
    tick(10);
    start_pulse(t1);
    wait_valids(v0 + 1, 100, to);
    checks++; if (to || valid_neg != t0 + 51) begin errors++; $display("FAIL busy_start_latency got=%0d exp=51", valid_neg - t0); end
    tick(80);
    checks++; if (valid_cnt != v0 + 1) begin errors++; $display("FAIL busy_start_count got=%0d exp=1", valid_cnt - v0); end
    // Reset mid-window discards the window and clears held results.
    per[0] = 10;
    gen_en = 2'b01;
    tick(20);
    gate_len = 16'd20;
    sb.push_back('{2, 0, 2'b00});
    v0 = valid_cnt;
    start_pulse(t0);
    wait_valids(v0 + 1, 40, to);
    checks++; if (freq[9:0] !== 10'd2) begin errors++; $display("FAIL prerst_freq got=%0d exp=2", freq[9:0]); end
    tick(5);
    gate_len = 16'd100;
    start_pulse(t0);
    tick(49);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (freq !== '0)   begin errors++; $display("FAIL rst_mid_freq got=%h exp=0", freq); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL rst_mid_ovf got=%b exp=00", ovf); end
    v1 = valid_cnt;
    tick(150);
    checks++; if (valid_cnt != v1) begin errors++; $display("FAIL rst_mid_valid got=%0d exp=0", valid_cnt - v1); end
    gens_off();
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_back_to_back();
    test_window_boundary();
    test_corners();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/freq_counter_mc.md
Name: freq_counter_mc

Overview:
Multi-channel, gate-time frequency counter. It is the parametrised successor of freq_counter. NUM_CH asynchronous measured signals are synchronised into the single clk_ref domain, and their rising edges are counted over a runtime-programmable gate window of clk_ref cycles. Single-shot and continuous modes are supported, with a valid strobe and per-channel overflow flags. It sits between raw pulse/clock inputs and register or UART readout logic.

Parameters:
NUM_CH, 4, number of measured channels
CNTR_SIZE, 16, per-channel edge counter / result width
GATE_W, 24, width of gate_len
SYNC_STAGES, 2, synchroniser flops per channel (minimum 2)

Ports:
clk_ref  in  1  reference clock; the only clock in the block
rst  in  1  reset, synchronous to clk_ref, active-high
meas_in  in  NUM_CH  asynchronous measured signals, bit i = channel i
gate_len  in  GATE_W  gate window length in clk_ref cycles, sampled at window start
start  in  1  single-shot trigger, level-sampled each cycle
continuous  in  1  1 = start windows back-to-back
freq  out  NUM_CH*CNTR_SIZE  results; channel i at [i*CNTR_SIZE +: CNTR_SIZE]
ovf  out  NUM_CH  per-channel saturation flag for the last completed window
valid  out  1  one-cycle strobe: freq/ovf updated
busy  out  1  high while a window is open

Behaviour:
- Reset (rst=1 at a clk_ref edge) clears synchronisers, edge-detect history, counters, freq, ovf, valid and busy. FSM goes to IDLE. Clock and reset are decided: one clock, reset synchronous and active-high.
- Per channel: SYNC_STAGES-flop synchroniser, then a rising-edge detect against a registered previous value (reset 0). edge_i is a one-cycle pulse. Input-to-edge_i latency is SYNC_STAGES+1 cycles. Correct counting requires a meas_in high and low time of at least 2 clk_ref cycles each.
- The edge detector runs in every state. Edges are accumulated only in GATE.
- FSM states: IDLE, GATE.
  - IDLE -> GATE when (start | continuous). The effective length is latched: len = (gate_len==0) ? 1 : gate_len. gate_cnt and all channel counters are cleared to 0.
  - GATE: busy=1. Each cycle, cnt_i <= sat(cnt_i + edge_i) and gate_cnt increments.
  - Last GATE cycle (gate_cnt == len-1):
    - freq_i <= sat(cnt_i + edge_i).
    - ovf_i <= 1 if saturation occurred at any point in the window.
    - Counters clear.
    - If continuous=1: stay in GATE, relatch gate_len, reset gate_cnt. The new window starts next cycle with no gap.
    - Else: go to IDLE.
- valid is registered. It is high exactly the cycle after the last GATE cycle, coincident with the new freq/ovf values.
- freq and ovf hold between valid strobes.
- Timing: with start sampled high in IDLE at cycle t, the window covers edges detected in cycles t+1 .. t+len. valid=1 at cycle t+len+1.
- Saturation: a counter at 2^CNTR_SIZE-1 holds there and sets its sticky window-overflow bit. That bit clears at window start.
- start while busy=1 is ignored.
- Clearing continuous mid-window: the current window completes with a normal valid, then the FSM goes to IDLE.
- gate_len changes mid-window have no effect until the next window start.
- rst mid-window: the window is discarded, no valid is produced, and outputs return to reset values.
- An edge detected on the last GATE cycle belongs to that window. An edge detected on the first cycle of the next window belongs to the next window. No edge is lost or double-counted across back-to-back windows.

Test Plan:
Configuration for all scenarios: NUM_CH=2, CNTR_SIZE=10, GATE_W=16, SYNC_STAGES=2.
1. Assert rst for 3 cycles with meas_in toggling -> freq=0, ovf=0, valid=0, busy=0. No valid for 50 cycles after release with start=0 and continuous=0.
2. ch0 square wave with period 10 clk_ref, ch1 held low; gate_len=1000; one-cycle start -> exactly one valid, 1001 cycles after start. freq ch0 = 100 (±1 for phase), ch1 = 0. busy then returns to 0.
3. ch0 period 4, gate_len=8000, start -> 2000 true edges exceed 1023, so freq ch0 = 1023 and ovf[0]=1. Rerun with gate_len=400 -> freq ch0 = 100 and ovf[0] clears.
4. continuous=1, gate_len=100, ch1 period 5 -> valid every 100 cycles, freq ch1 = 20 each time. The summed count over 10 windows equals the total edges driven. Drop continuous mid-window -> one more valid, then busy=0.
5. Force a single ch0 edge so that it is detected on the last GATE cycle -> counted in that window (freq=1). Repeat with the edge detected on the first cycle of the following window -> counted in the next window.
6. Corner cases:
   - gate_len=0 -> window of 1 cycle, valid 2 cycles after start.
   - start pulse during busy -> ignored.
   - rst at mid-window cycle 50 -> busy=0 and no valid strobe.
